// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow complete in one cycle without iterating.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  // Handshake: start is taken at a rising edge only in IDLE/DONE with flush low;
  // valid is a one-cycle pulse (DONE) qualifying result, and no ready is needed
  // because the consumer stalls on busy.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            is_rem_q, is_rem_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            accept;
  logic            op_signed;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            ovf;
  logic            bypass;
  logic            last_step;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   sub;
  logic            borrow;
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;

  always_comb begin
    accept    = start && !flush && (state_q == IDLE || state_q == DONE);
    op_signed = ~op[0];
    a_neg     = op_signed & a[XLEN-1];
    b_neg     = op_signed & b[XLEN-1];
    div_zero  = (b == '0);
    ovf       = op_signed && (a == MIN_NEG) && (b == '1);
    bypass    = div_zero || ovf;
    last_step = (cnt_q == 5'd31);
  end

  // One restoring step; the borrow out of the wide subtract decides the quotient bit.
  always_comb begin
    shifted       = {rem_q, quo_q[XLEN-1]};
    {borrow, sub} = {1'b0, shifted} - {2'b00, dvs_q};
    step_rem      = borrow ? shifted[XLEN-1:0] : sub[XLEN-1:0];
    step_quo      = {quo_q[XLEN-2:0], ~borrow};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = bypass ? DONE : CALC;
        CALC:    if (last_step) state_d = DONE;
        DONE:    state_d = accept ? (bypass ? DONE : CALC) : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q == CALC);
    valid     = (state_q == DONE);
    dbg_state = state_q;
    result    = result_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    if (flush) begin
      cnt_d = '0;
    end else if (accept) begin
      is_rem_d = op[1];
      if (bypass) begin
        if (div_zero) result_d = op[1] ? a : '1;
        else          result_d = op[1] ? '0 : MIN_NEG;
      end else begin
        rem_d   = '0;
        quo_d   = a_neg ? -a : a;
        dvs_d   = b_neg ? -b : b;
        q_neg_d = a_neg ^ b_neg;
        r_neg_d = a_neg;
        cnt_d   = '0;
      end
    end else if (state_q == CALC) begin
      rem_d = step_rem;
      quo_d = step_quo;
      cnt_d = cnt_q + 5'd1;
      if (last_step) begin
        if (is_rem_q) result_d = r_neg_q ? -step_rem : step_rem;
        else          result_d = q_neg_q ? -step_quo : step_quo;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      is_rem_q <= is_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, hand-written flush/reset/back-to-back
// sequences, and random operations checked against an arithmetic reference.
module tb_div_unit;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        valid;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .valid(valid), .result(result),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy, sr;
    sx = x;
    sy = y;
    if (y == 32'h0) return o[1] ? x : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
      sr = o[1] ? (sx % sy) : (sx / sy);
      return sr;
    end
    return o[1] ? (x % y) : (x / y);
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    if (y == 32'h0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Issues one op; lat = edges after accept until valid is seen (0 = timeout).
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit noise, output logic [31:0] r, output int lat,
                        output bit busy_seen);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_seen = 1'b0;
    r = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      busy_seen = busy_seen | busy;
      if (valid) begin
        lat = i;
        r = result;
        break;
      end
      if (noise && (i % 5 == 0) && i <= 28) begin
        start = 1'b1; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      end
    end
  endtask

  task automatic apply(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit noise);
    logic [31:0] r;
    int lat;
    bit bs;
    int el;
    el = ref_lat(o, x, y);
    run_op(o, x, y, noise, r, lat, bs);
    check({name, " result"}, r, ref_result(o, x, y));
    check({name, " latency"}, 32'(lat), 32'(el));
    check({name, " busy_seen"}, {31'h0, bs}, {31'h0, el != 1});
  endtask

  initial begin
    logic [31:0] r1, r2, held;
    int lat, gap, vseen;
    bit bs;

    vecs.push_back('{2'b00, 32'd100,        32'd7,          32'd14,         33});
    vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
    vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33});
    vecs.push_back('{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{2'b11, 32'd5,          32'd0,          32'd5,          1});
    vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
    vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1});
    vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33});
    vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33});
    vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          33});
    vecs.push_back('{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33});
    vecs.push_back('{2'b10, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFF8,  1});
    vecs.push_back('{2'b00, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFFF,  1});
    vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          33});
    vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          33});
    vecs.push_back('{2'b10, 32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  33});

    rstn = 1'b0; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0; flush = 1'b0;
    #23;
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset valid", {31'h0, valid}, 32'h0);
    check("reset result", result, 32'h0);
    @(posedge clk); #2;
    rstn = 1'b1;

    // The first op lands on the first edge after reset release.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, r1, lat, bs);
      check($sformatf("vec%0d result", i), r1, vecs[i].exp_r);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d busy_seen", i), {31'h0, bs}, {31'h0, vecs[i].exp_lat != 1});
    end

    // Flush at E10 aborts; result keeps the previous value.
    held = ref_result(vecs[vecs.size()-1].op, vecs[vecs.size()-1].a, vecs[vecs.size()-1].b);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {31'h0, busy}, 32'h0);
    check("flush valid", {31'h0, valid}, 32'h0);
    check("flush result held", result, held);
    apply("after flush", 2'b00, 32'd1000, 32'd3, 1'b0);

    // Flush wins over a simultaneous start.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd9; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush+start busy", {31'h0, busy}, 32'h0);
    check("flush+start valid", {31'h0, valid}, 32'h0);
    @(posedge clk); #1;
    check("flush+start valid later", {31'h0, valid}, 32'h0);

    apply("start ignored in calc", 2'b10, 32'hDEAD_BEEF, 32'd12345, 1'b1);

    // Back-to-back: the second start is driven in the DONE cycle of the first.
    run_op(2'b01, 32'd77777, 32'd13, 1'b0, r1, lat, bs);
    check("b2b first result", r1, ref_result(2'b01, 32'd77777, 32'd13));
    start = 1'b1; op = 2'b00; a = 32'hFFFF_0000; b = 32'd9;
    gap = 0;
    r2 = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (valid) begin
        gap = i;
        r2 = result;
        break;
      end
    end
    check("b2b valid gap", 32'(gap), 32'd33);
    check("b2b second result", r2, ref_result(2'b00, 32'hFFFF_0000, 32'd9));

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd500; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("async reset busy", {31'h0, busy}, 32'h0);
    check("async reset valid", {31'h0, valid}, 32'h0);
    check("async reset result", result, 32'h0);
    @(posedge clk); #2;
    rstn = 1'b1;
    vseen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid) vseen++;
    end
    check("no valid after reset", 32'(vseen), 32'h0);

    for (int i = 0; i < 150; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'h0;
        1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2, 3:    rb = 32'($urandom_range(1, 20));
        4:       rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      apply($sformatf("rand%0d", i), ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
